cnn_conv_quad_core: RTL and testbench
=====================================

Name: cnn_conv_quad_core

Overview:
- Single-clock convolution engine for one quad of NUM_CE compute lanes (depth channels).
- Takes a job descriptor, fetches one 3x3 kernel set and one input image over valid/ready streams, and computes a stride-1, unpadded 3D convolution.
- Emits 16-bit results through a valid/accept stream, then signals job completion.
- Sits between the job scheduler/fetch engine and the result collector.

Parameters:
- NUM_CE, 4, depth channels per pixel beat (lanes 0..NUM_CE-1 of pixel_data/weight_data, 16 bits each).
- MAX_DIM, 32, maximum input rows/cols.
- MAX_KERNELS, 8, maximum kernels per job.

Ports:
- clk_core  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- job_start  in  1  request new job.
- job_accept  out  1  one-cycle pulse when job latched.
- job_parameters  in  128  descriptor: [7:0] rows, [15:8] cols, [23:16] num_kernels, [27:24] kernel_size, [31:28] stride, [35:32] padding.
- job_fetch_request  out  1  requests weight/pixel fetch.
- job_fetch_ack  in  1  fetcher acknowledges request.
- job_fetch_complete  in  1  fetcher finished sending.
- job_complete  out  1  job done, held until ack.
- job_complete_ack  in  1  acknowledges completion.
- weight_valid/weight_ready  in/out  1  weight stream handshake.
- weight_data  in  128  NUM_CE signed 16-bit weights.
- pixel_valid/pixel_ready  in/out  1  pixel stream handshake.
- pixel_data  in  128  NUM_CE signed 16-bit pixels.
- result_valid/result_accept  out/in  1  result handshake.
- result_data  out  16  signed result.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters cleared. Reset mid-job aborts the job, discards buffers, and requires no ack.
- IDLE: when job_start=1, latch job_parameters and pulse job_accept for 1 cycle, then go to FETCH.
  - Only kernel_size=3, stride=1, padding=0 are supported; other values are latched but computed as 3/1/0.
  - rows, cols >= 3 and <= MAX_DIM; num_kernels 1..MAX_KERNELS.
- FETCH: hold job_fetch_request=1 until the cycle after job_fetch_ack=1.
  - Weights: num_kernels*9 beats, kernel-major, then tap row-major (ky, kx).
  - Pixels: rows*cols beats, row-major.
  - A beat transfers on valid&ready. Each ready stays high until its count is reached, then drops.
  - Weight and pixel beats may interleave or arrive simultaneously.
  - Leave FETCH when both counts are reached and job_fetch_complete has been seen (sticky).
  - Excess beats are not accepted (ready=0).
- COMPUTE: output rows OR=rows-2, cols OC=cols-2. Ordering is row, then col, then kernel innermost.
  - Each result = sum over 9 taps and NUM_CE lanes of pixel*weight.
  - One tap per cycle (NUM_CE parallel multipliers), 9 cycles per result.
  - Accumulate in 40-bit signed, then saturate to signed 16-bit (0x7FFF / 0x8000).
- RESULT: result_valid=1 with result_data stable until result_accept=1; the next computation starts after the transfer. No result is dropped under backpressure.
- After the last of OR*OC*num_kernels results, assert job_complete; hold until job_complete_ack, then return to IDLE.
- job_start outside IDLE is ignored.

Decomposition:
- Shared package cnn_quad_pkg:
  - job descriptor field offsets/widths.
  - FSM state enum (IDLE, FETCH, COMPUTE, RESULT, DONE).
  - Lane width 16 and accumulator width 40.
  - Saturation function.
- One sub-module, cnn_quad_mac_lane_array: NUM_CE multipliers, adder tree, and 40-bit accumulator with clear/enable.

Test Plan:
- 5x5 pixels, all lanes 1; 1 kernel, all weights 1 -> 9 results, each 36, then job_complete; after ack, job_accept again on next job_start.
- 31x31, depth 4, 2 kernels, random 8-bit values -> 29*29*2=1682 results matching a reference model, in row/col/kernel order.
- Identity kernel (center tap, lane 0 =1, others 0), 4x4 ramp image p=r*4+c -> results 5,6,9,10.
- Pixels 0x7FFF, weights 0x7FFF, 3x3 image -> single result 0x7FFF; with negated weights -> 0x8000.
- result_accept held low 20 cycles mid-stream -> result_data is stable, then the sequence continues with no loss or duplication.
- rst asserted during FETCH -> all outputs 0 immediately; a fresh job then completes correctly.

Source files
------------

// File: rtl/cnn_conv_quad_core_pkg.sv
// Shared definitions for the convolution quad core.
// Holds the job descriptor layout, the controller state encoding, datapath
// widths and the 16-bit saturation helper used on the result path.
package cnn_quad_pkg;

  localparam int LANE_W = 16;
  localparam int ACC_W  = 40;

  // Descriptor field offsets / widths inside job_parameters
  localparam int ROWS_LSB   = 0;
  localparam int COLS_LSB   = 8;
  localparam int NK_LSB     = 16;
  localparam int KS_LSB     = 24;
  localparam int STRIDE_LSB = 28;
  localparam int PAD_LSB    = 32;
  localparam int DIM_W      = 8;
  localparam int CFG_W      = 4;

  typedef struct packed {
    logic [CFG_W-1:0] padding;
    logic [CFG_W-1:0] stride;
    logic [CFG_W-1:0] kernel_size;
    logic [DIM_W-1:0] num_kernels;
    logic [DIM_W-1:0] cols;
    logic [DIM_W-1:0] rows;
  } job_desc_t;

  localparam int DESC_W = $bits(job_desc_t);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_COMPUTE,
    ST_RESULT,
    ST_DONE
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

  function automatic logic [LANE_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) return 16'h7FFF;
    else if (v < SAT_MIN) return 16'h8000;
    else return v[LANE_W-1:0];
  endfunction

endpackage

// File: rtl/cnn_conv_quad_core_if.sv
// Handshake bundle between the quad core and its job scheduler, fetch
// engine and result collector.
//   master : scheduler / fetcher / collector side (drives job, streams, accept)
//   slave  : the core (drives accept pulses, readies, results, completion)
interface cnn_conv_quad_core_if;
  logic         job_start;
  logic         job_accept;
  logic [127:0] job_parameters;
  logic         job_fetch_request;
  logic         job_fetch_ack;
  logic         job_fetch_complete;
  logic         job_complete;
  logic         job_complete_ack;
  logic         weight_valid;
  logic         weight_ready;
  logic [127:0] weight_data;
  logic         pixel_valid;
  logic         pixel_ready;
  logic [127:0] pixel_data;
  logic         result_valid;
  logic         result_accept;
  logic [15:0]  result_data;

  modport master (
    output job_start, job_parameters, job_fetch_ack, job_fetch_complete,
           job_complete_ack, weight_valid, weight_data, pixel_valid,
           pixel_data, result_accept,
    input  job_accept, job_fetch_request, job_complete, weight_ready,
           pixel_ready, result_valid, result_data
  );

  modport slave (
    input  job_start, job_parameters, job_fetch_ack, job_fetch_complete,
           job_complete_ack, weight_valid, weight_data, pixel_valid,
           pixel_data, result_accept,
    output job_accept, job_fetch_request, job_complete, weight_ready,
           pixel_ready, result_valid, result_data
  );
endinterface

// File: rtl/cnn_quad_mac_lane_array.sv
// NUM_CE parallel signed 16x16 multipliers summed into a 40-bit accumulator.
// Ports:
//   clk_core, rst : clock, async active-low reset
//   clr           : this tap starts a new sum (products load instead of add)
//   en            : update the accumulator this cycle
//   pix, wgt      : NUM_CE packed signed 16-bit lanes
//   sum_next      : value the accumulator takes on an enabled edge
module cnn_quad_mac_lane_array
  import cnn_quad_pkg::*;
#(
  parameter int NUM_CE = 4
) (
  input  logic                       clk_core,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  input  logic [NUM_CE*LANE_W-1:0]   pix,
  input  logic [NUM_CE*LANE_W-1:0]   wgt,
  output logic signed [ACC_W-1:0]   sum_next
);

  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    prod_sum;
  logic signed [LANE_W-1:0]   pix_l  [NUM_CE];
  logic signed [LANE_W-1:0]   wgt_l  [NUM_CE];
  logic signed [2*LANE_W-1:0] prod   [NUM_CE];

  always_comb begin
    prod_sum = '0;
    for (int l = 0; l < NUM_CE; l++) begin
      pix_l[l] = pix[l*LANE_W +: LANE_W];
      wgt_l[l] = wgt[l*LANE_W +: LANE_W];
      prod[l]  = pix_l[l] * wgt_l[l];
      prod_sum = prod_sum + ACC_W'(prod[l]);
    end
  end

  assign sum_next = clr ? prod_sum : acc + prod_sum;

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) acc <= '0;
    else if (en) acc <= sum_next;
  end

endmodule

// File: rtl/cnn_conv_quad_core.sv
// Convolution engine for one quad of NUM_CE depth lanes: latches a job,
// buffers one 3x3 kernel set and one image, then streams stride-1 unpadded
// convolution results (row, col, kernel order) saturated to 16 bits.
// Ports:
//   clk_core : sole clock
//   rst      : async active-low reset, aborts any job in flight
//   bus      : job / fetch / weight / pixel / result handshakes (slave side)
//
// state      | meaning
// ST_IDLE    | waiting for job_start
// ST_FETCH   | requesting and buffering weights and pixels
// ST_COMPUTE | one 3x3 tap per cycle into the MAC array
// ST_RESULT  | result_valid held until result_accept
// ST_DONE    | job_complete held until job_complete_ack
module cnn_conv_quad_core
  import cnn_quad_pkg::*;
#(
  parameter int NUM_CE      = 4,
  parameter int MAX_DIM     = 32,
  parameter int MAX_KERNELS = 8
) (
  input  logic                  clk_core,
  input  logic                  rst,
  cnn_conv_quad_core_if.slave   bus
);

  localparam int LANES_W    = NUM_CE * LANE_W;
  localparam int WBUF_DEPTH = MAX_KERNELS * 9;
  localparam int PBUF_DEPTH = MAX_DIM * MAX_DIM;
  localparam int WADDR_W    = $clog2(WBUF_DEPTH);
  localparam int PADDR_W    = $clog2(PBUF_DEPTH);
  localparam int WCNT_W     = $clog2(WBUF_DEPTH + 1);
  localparam int PCNT_W     = $clog2(PBUF_DEPTH + 1);
  localparam int RES_W      = $clog2(PBUF_DEPTH * MAX_KERNELS + 1);
  localparam int KIDX_W     = $clog2(MAX_KERNELS);
  localparam int POS_W      = $clog2(MAX_DIM);

  logic [LANES_W-1:0] wbuf [WBUF_DEPTH];
  logic [LANES_W-1:0] pbuf [PBUF_DEPTH];

  state_t             state;
  job_desc_t          desc;
  job_desc_t          desc_in;
  logic [WCNT_W-1:0]  w_cnt, w_total;
  logic [PCNT_W-1:0]  p_cnt, p_total;
  logic [RES_W-1:0]   res_left;
  logic               fc_seen;
  logic [1:0]         ky, kx;
  logic [KIDX_W-1:0]  k_idx;
  logic [POS_W-1:0]   orow, ocol;

  logic               job_accept_q, fetch_req_q, job_complete_q, result_valid_q;
  logic [LANE_W-1:0]  result_data_q;

  logic               w_fire, p_fire;
  logic [WADDR_W-1:0] w_addr;
  logic [PADDR_W-1:0] p_addr;
  logic               mac_clr, mac_en;
  logic signed [ACC_W-1:0] mac_sum;

  assign desc_in = job_desc_t'(bus.job_parameters[DESC_W-1:0]);

  assign bus.weight_ready      = (state == ST_FETCH) && (w_cnt != w_total);
  assign bus.pixel_ready       = (state == ST_FETCH) && (p_cnt != p_total);
  assign bus.job_accept        = job_accept_q;
  assign bus.job_fetch_request = fetch_req_q;
  assign bus.job_complete      = job_complete_q;
  assign bus.result_valid      = result_valid_q;
  assign bus.result_data       = result_data_q;

  assign w_fire = bus.weight_valid && bus.weight_ready;
  assign p_fire = bus.pixel_valid && bus.pixel_ready;

  // Buffers carry no reset: counters define what is valid, so an aborted
  // job simply leaves stale contents that the next fetch overwrites.
  always_ff @(posedge clk_core) begin
    if (w_fire) wbuf[w_cnt[WADDR_W-1:0]] <= bus.weight_data[LANES_W-1:0];
    if (p_fire) pbuf[p_cnt[PADDR_W-1:0]] <= bus.pixel_data[LANES_W-1:0];
  end

  assign w_addr = WADDR_W'(int'(k_idx) * 9 + int'(ky) * 3 + int'(kx));
  assign p_addr = PADDR_W'((int'(orow) + int'(ky)) * int'(desc.cols)
                           + int'(ocol) + int'(kx));

  assign mac_en  = (state == ST_COMPUTE);
  assign mac_clr = (ky == 2'd0) && (kx == 2'd0);

  cnn_quad_mac_lane_array #(.NUM_CE(NUM_CE)) u_mac (
    .clk_core (clk_core),
    .rst      (rst),
    .clr      (mac_clr),
    .en       (mac_en),
    .pix      (pbuf[p_addr]),
    .wgt      (wbuf[w_addr]),
    .sum_next (mac_sum)
  );

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      desc           <= '0;
      w_cnt          <= '0;
      w_total        <= '0;
      p_cnt          <= '0;
      p_total        <= '0;
      res_left       <= '0;
      fc_seen        <= 1'b0;
      ky             <= '0;
      kx             <= '0;
      k_idx          <= '0;
      orow           <= '0;
      ocol           <= '0;
      job_accept_q   <= 1'b0;
      fetch_req_q    <= 1'b0;
      job_complete_q <= 1'b0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
    end else begin
      job_accept_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.job_start) begin
            // kernel_size/stride/padding are kept but the datapath is fixed 3/1/0
            desc         <= desc_in;
            w_total      <= WCNT_W'(int'(desc_in.num_kernels) * 9);
            p_total      <= PCNT_W'(int'(desc_in.rows) * int'(desc_in.cols));
            res_left     <= RES_W'((int'(desc_in.rows) - 2) * (int'(desc_in.cols) - 2)
                                   * int'(desc_in.num_kernels));
            w_cnt        <= '0;
            p_cnt        <= '0;
            fc_seen      <= 1'b0;
            fetch_req_q  <= 1'b1;
            job_accept_q <= 1'b1;
            state        <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (w_fire) w_cnt <= w_cnt + 1'b1;
          if (p_fire) p_cnt <= p_cnt + 1'b1;
          if (bus.job_fetch_ack) fetch_req_q <= 1'b0;
          if (bus.job_fetch_complete) fc_seen <= 1'b1;
          if ((w_cnt == w_total) && (p_cnt == p_total) &&
              (fc_seen || bus.job_fetch_complete)) begin
            fetch_req_q <= 1'b0;
            ky          <= '0;
            kx          <= '0;
            k_idx       <= '0;
            orow        <= '0;
            ocol        <= '0;
            state       <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          if (kx == 2'd2) begin
            kx <= '0;
            if (ky == 2'd2) begin
              ky             <= '0;
              result_data_q  <= sat16(mac_sum);
              result_valid_q <= 1'b1;
              state          <= ST_RESULT;
            end else begin
              ky <= ky + 1'b1;
            end
          end else begin
            kx <= kx + 1'b1;
          end
        end
        ST_RESULT: begin
          if (bus.result_accept) begin
            result_valid_q <= 1'b0;
            res_left       <= res_left - 1'b1;
            if (res_left == RES_W'(1)) begin
              job_complete_q <= 1'b1;
              state          <= ST_DONE;
            end else begin
              state <= ST_COMPUTE;
              if (int'(k_idx) == int'(desc.num_kernels) - 1) begin
                k_idx <= '0;
                if (int'(ocol) == int'(desc.cols) - 3) begin
                  ocol <= '0;
                  orow <= orow + 1'b1;
                end else begin
                  ocol <= ocol + 1'b1;
                end
              end else begin
                k_idx <= k_idx + 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          if (bus.job_complete_ack) begin
            job_complete_q <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Descriptor and lane bits the fixed-geometry datapath never reads.
  logic unused_desc;
  assign unused_desc = ^{desc.rows, desc.kernel_size, desc.stride, desc.padding,
                         bus.job_parameters[127:DESC_W]};

  if (LANES_W < 128) begin : g_unused_lanes
    logic unused_lanes;
    assign unused_lanes = ^{bus.weight_data[127:LANES_W], bus.pixel_data[127:LANES_W]};
  end

endmodule

// File: tb/tb_cnn_conv_quad_core.sv
module tb_cnn_conv_quad_core;
  import cnn_quad_pkg::*;

  logic clk_core = 1'b0;
  logic rst      = 1'b0;
  always #5 clk_core = ~clk_core;

  cnn_conv_quad_core_if bus();

  cnn_conv_quad_core #(.NUM_CE(4), .MAX_DIM(32), .MAX_KERNELS(8)) dut (
    .clk_core (clk_core),
    .rst      (rst),
    .bus      (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic signed [15:0] tpix [1024][4];
  logic signed [15:0] twgt [72][4];
  logic [15:0]        exp_res [2048];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_data();
    for (int i = 0; i < 1024; i++) for (int l = 0; l < 4; l++) tpix[i][l] = '0;
    for (int i = 0; i < 72; i++)   for (int l = 0; l < 4; l++) twgt[i][l] = '0;
  endtask

  function automatic logic [127:0] pack_w(input int i);
    logic [127:0] v = '0;
    for (int l = 0; l < 4; l++) v[l*16 +: 16] = twgt[i][l];
    return v;
  endfunction

  function automatic logic [127:0] pack_p(input int i);
    logic [127:0] v = '0;
    for (int l = 0; l < 4; l++) v[l*16 +: 16] = tpix[i][l];
    return v;
  endfunction

  // Direct reference convolution, row / col / kernel order.
  task automatic model(input int rows, input int cols, input int nk);
    int idx = 0;
    for (int r = 0; r < rows - 2; r++)
      for (int c = 0; c < cols - 2; c++)
        for (int k = 0; k < nk; k++) begin
          longint s = 0;
          for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++)
              for (int l = 0; l < 4; l++)
                s += longint'(tpix[(r + y) * cols + c + x][l]) * longint'(twgt[k * 9 + y * 3 + x][l]);
          if (s > 32767) exp_res[idx] = 16'h7FFF;
          else if (s < -32768) exp_res[idx] = 16'h8000;
          else exp_res[idx] = 16'(s);
          idx++;
        end
  endtask

  task automatic start_job(input int rows, input int cols, input int nk);
    @(negedge clk_core);
    bus.job_parameters = {92'd0, 4'd0, 4'd1, 4'd3, 8'(nk), 8'(cols), 8'(rows)};
    bus.job_start = 1'b1;
    @(negedge clk_core);
    bus.job_start = 1'b0;
    check("job_accept", 64'(bus.job_accept), 64'd1);
    @(negedge clk_core);
    check("job_accept_pulse", 64'(bus.job_accept), 64'd0);
  endtask

  task automatic fetch_data(input int rows, input int cols, input int nk);
    int wt = nk * 9;
    int pt = rows * cols;
    int wi = 0;
    int pi = 0;
    int guard = 0;
    logic wf, pf;
    check("fetch_request", 64'(bus.job_fetch_request), 64'd1);
    bus.job_fetch_ack = 1'b1;
    @(negedge clk_core);
    bus.job_fetch_ack = 1'b0;
    check("fetch_request_drop", 64'(bus.job_fetch_request), 64'd0);
    while ((wi < wt || pi < pt) && guard < 5000) begin
      guard++;
      bus.weight_valid = (wi < wt) && ($urandom_range(0, 3) != 0);
      bus.weight_data  = pack_w(wi < wt ? wi : 0);
      bus.pixel_valid  = (pi < pt) && ($urandom_range(0, 7) != 0);
      bus.pixel_data   = pack_p(pi < pt ? pi : 0);
      wf = bus.weight_valid && bus.weight_ready;
      pf = bus.pixel_valid && bus.pixel_ready;
      @(negedge clk_core);
      if (wf) wi++;
      if (pf) pi++;
    end
    check("fetch_beats", {32'(wi), 32'(pi)}, {32'(wt), 32'(pt)});
    bus.weight_valid = 1'b1;
    bus.pixel_valid  = 1'b1;
    check("excess_ready", {62'd0, bus.weight_ready, bus.pixel_ready}, 64'd0);
    @(negedge clk_core);
    bus.weight_valid = 1'b0;
    bus.pixel_valid  = 1'b0;
    bus.job_fetch_complete = 1'b1;
    @(negedge clk_core);
    bus.job_fetch_complete = 1'b0;
  endtask

  task automatic collect(input int n, input int stall_idx);
    for (int i = 0; i < n; i++) begin
      int g = 0;
      while (!bus.result_valid && g < 100) begin
        @(negedge clk_core);
        g++;
      end
      if (i == stall_idx) begin
        logic [15:0] held = bus.result_data;
        logic stable = 1'b1;
        repeat (20) begin
          @(negedge clk_core);
          if (bus.result_data !== held || bus.result_valid !== 1'b1) stable = 1'b0;
        end
        check("stall_stable", 64'(stable), 64'd1);
      end
      check($sformatf("result[%0d]", i), {47'd0, bus.result_valid, bus.result_data},
            {47'd0, 1'b1, exp_res[i]});
      bus.result_accept = 1'b1;
      @(negedge clk_core);
      bus.result_accept = 1'b0;
    end
    check("job_complete", {62'd0, bus.job_complete, bus.result_valid}, 64'd2);
    bus.job_complete_ack = 1'b1;
    @(negedge clk_core);
    bus.job_complete_ack = 1'b0;
    check("job_complete_clear", 64'(bus.job_complete), 64'd0);
  endtask

  task automatic run_job(input int rows, input int cols, input int nk, input int stall_idx);
    start_job(rows, cols, nk);
    fetch_data(rows, cols, nk);
    bus.job_start = 1'b1;
    @(negedge clk_core);
    bus.job_start = 1'b0;
    check("start_ignored", 64'(bus.job_accept), 64'd0);
    collect((rows - 2) * (cols - 2) * nk, stall_idx);
  endtask

  function automatic logic [63:0] out_vec();
    return {42'd0, bus.job_accept, bus.job_fetch_request, bus.job_complete,
            bus.weight_ready, bus.pixel_ready, bus.result_valid, bus.result_data};
  endfunction

  task automatic setup_ones();
    clear_data();
    for (int i = 0; i < 25; i++) for (int l = 0; l < 4; l++) tpix[i][l] = 16'sd1;
    for (int i = 0; i < 9; i++)  for (int l = 0; l < 4; l++) twgt[i][l] = 16'sd1;
    for (int i = 0; i < 9; i++) exp_res[i] = 16'd36;
  endtask

  initial begin
    bus.job_start = 0; bus.job_parameters = '0; bus.job_fetch_ack = 0;
    bus.job_fetch_complete = 0; bus.job_complete_ack = 0;
    bus.weight_valid = 0; bus.weight_data = '0;
    bus.pixel_valid = 0; bus.pixel_data = '0; bus.result_accept = 0;

    repeat (3) @(negedge clk_core);
    check("reset_outputs", out_vec(), 64'd0);
    rst = 1'b1;

    // 5x5 all-ones image and kernel: every output is 9 taps * 4 lanes = 36
    setup_ones();
    run_job(5, 5, 1, -1);

    // identity kernel on a 4x4 ramp picks the centre pixel of each window
    clear_data();
    for (int i = 0; i < 16; i++) tpix[i][0] = 16'(i);
    twgt[4][0] = 16'sd1;
    exp_res[0] = 16'd5; exp_res[1] = 16'd6; exp_res[2] = 16'd9; exp_res[3] = 16'd10;
    run_job(4, 4, 1, -1);

    // saturation, both directions
    clear_data();
    for (int i = 0; i < 9; i++) for (int l = 0; l < 4; l++) begin
      tpix[i][l] = 16'sh7FFF;
      twgt[i][l] = 16'sh7FFF;
    end
    exp_res[0] = 16'h7FFF;
    run_job(3, 3, 1, -1);
    for (int i = 0; i < 9; i++) for (int l = 0; l < 4; l++) twgt[i][l] = -16'sh7FFF;
    exp_res[0] = 16'h8000;
    run_job(3, 3, 1, -1);

    // reset in the middle of a fetch
    setup_ones();
    start_job(5, 5, 1);
    bus.job_fetch_ack = 1'b1;
    @(negedge clk_core);
    bus.job_fetch_ack = 1'b0;
    bus.weight_valid = 1'b1;
    bus.weight_data  = pack_w(0);
    repeat (3) @(negedge clk_core);
    rst = 1'b0;
    #1;
    check("reset_mid_fetch", out_vec(), 64'd0);
    bus.weight_valid = 1'b0;
    @(negedge clk_core);
    rst = 1'b1;
    run_job(5, 5, 1, -1);

    // 31x31, two kernels, random signed 8-bit data, backpressure at result 100
    clear_data();
    for (int i = 0; i < 961; i++) for (int l = 0; l < 4; l++)
      tpix[i][l] = 16'($signed($urandom_range(0, 255)) - 128);
    for (int i = 0; i < 18; i++) for (int l = 0; l < 4; l++)
      twgt[i][l] = 16'($signed($urandom_range(0, 255)) - 128);
    model(31, 31, 2);
    run_job(31, 31, 2, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
